// File: rtl/utype_exec_seq.sv
// ---------------------------------------------------------------------------
// utype_exec_seq
//
// Multi-cycle fetch/decode/writeback sequencer for the RV32 U-type subset
// (LUI / AUIPC). Owns the program counter, fetches one instruction word per
// pass over a req/ack instruction port, computes the U-type result and drives
// a single register-file write port. Any other opcode is flagged as illegal
// and skipped without a write.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous reset, active-high
//   i_en           run enable, sampled at instruction boundaries
//   o_imem_req     fetch request (high throughout FETCH)
//   o_imem_addr    fetch address (always the current pc)
//   i_imem_ack     fetch complete, i_imem_rdata valid this cycle
//   i_imem_rdata   fetched instruction word
//   o_rf_we        register-file write strobe (registered, one cycle in WB)
//   o_rf_waddr     write register index, inst[11:7]
//   o_rf_wdata     write data
//   o_pc           current program counter
//   o_illegal      one-cycle pulse in DECODE for a non-U-type opcode
//   o_retired      count of retired legal instructions (wraps)
//   o_busy         high in any state other than IDLE
//
// FSM
//   state  | meaning
//   IDLE   | parked, outputs quiet, waits for i_en
//   FETCH  | request word at pc, hold until ack
//   DECODE | classify opcode, compute result or skip illegal word
//   WB     | write strobe active, pc and retired advance on exit
// ---------------------------------------------------------------------------
module utype_exec_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    output logic             o_imem_req,
    output logic [31:0]      o_imem_addr,
    input  logic             i_imem_ack,
    input  logic [31:0]      i_imem_rdata,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_waddr,
    output logic [31:0]      o_rf_wdata,
    output logic [31:0]      o_pc,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_retired,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_DECODE = 2'd2;
    localparam logic [1:0] S_WB     = 2'd3;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    function automatic logic is_utype(input logic [6:0] opcode);
        return (opcode == OP_LUI) || (opcode == OP_AUIPC);
    endfunction

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_pc;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_retired;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic [31:0]      r_rf_wdata;
    logic             r_illegal;

    // -----------------------------------------------------------------------
    // Instruction field split
    // -----------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [19:0] w_imm;
    logic [31:0] w_imm_shifted;
    logic        w_legal;
    logic [31:0] w_result;
    logic [31:0] w_pc_inc;

    assign w_opcode      = r_ir[6:0];
    assign w_rd          = r_ir[11:7];
    assign w_imm         = r_ir[31:12];
    assign w_imm_shifted = {w_imm, 12'h000};
    assign w_legal       = is_utype(w_opcode);
    assign w_pc_inc      = r_pc + 32'd4;

    // AUIPC adds to the pc of the instruction itself; pc has not yet moved
    // while in DECODE, so r_pc is the right operand. Carry out is dropped.
    always_comb begin
        w_result = w_imm_shifted;
        if (w_opcode == OP_AUIPC) begin
            w_result = r_pc + w_imm_shifted;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_en) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_imem_ack) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_nxt = S_WB;
                end else if (i_en) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                if (i_en) begin
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_ir       <= 32'h0000_0000;
            r_retired  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= 5'd0;
            r_rf_wdata <= 32'h0000_0000;
            r_illegal  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            // Strobes default low so each is a single-cycle pulse.
            r_rf_we   <= 1'b0;
            r_illegal <= 1'b0;

            case (r_state)
                S_FETCH: begin
                    if (i_imem_ack) begin
                        r_ir      <= i_imem_rdata;
                        // Classified from the raw word so the registered
                        // pulse lines up with the DECODE cycle.
                        r_illegal <= ~is_utype(i_imem_rdata[6:0]);
                    end
                end
                S_DECODE: begin
                    if (w_legal) begin
                        r_rf_waddr <= w_rd;
                        r_rf_wdata <= w_result;
                        // x0 writes are suppressed but still retire in WB.
                        r_rf_we    <= (w_rd != 5'd0);
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                S_WB: begin
                    r_pc      <= w_pc_inc;
                    r_retired <= r_retired + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign o_imem_req  = (r_state == S_FETCH);
    assign o_imem_addr = r_pc;
    assign o_busy      = (r_state != S_IDLE);
    assign o_pc        = r_pc;
    assign o_retired   = r_retired;
    assign o_rf_we     = r_rf_we;
    assign o_rf_waddr  = r_rf_waddr;
    assign o_rf_wdata  = r_rf_wdata;
    assign o_illegal   = r_illegal;

endmodule
